// File: rtl/if_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
package if_pkg;

  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } if_state_e;

  localparam int unsigned INST_BYTES = 4;

  // Ceiling log2 for index and pointer widths.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'(1) << r) < 64'(value)) r++;
    return r;
  endfunction

endpackage

// File: rtl/if_imem.sv
// Single-port instruction RAM with one-cycle synchronous read.
module if_imem #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned INST_W = 32,
  localparam int unsigned ADDR_W = if_pkg::clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [INST_W-1:0] wdata,
  output logic [INST_W-1:0] rdata
);

  logic [INST_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/if_stage_pipe.sv
// Fetch stage: boot-load path into imem, fetch PC with redirect, valid/ready buffer.
// Define IF_PERF_CNT_EN to add the perf_fetch_cnt / perf_redirect_cnt outputs.
module if_stage_pipe
  import if_pkg::*;
#(
  parameter int unsigned PC_W      = 16,
  parameter int unsigned INST_W    = 32,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned RESET_PC  = 0,
  parameter int unsigned BUF_DEPTH = 2,
  localparam int unsigned IDX_W    = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              boot_up,
  input  logic              boot_we,
  input  logic [IDX_W-1:0]  boot_addr,
  input  logic [INST_W-1:0] boot_data,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              pc_run,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   inst_pc,
  output logic [PC_W-1:0]   inst_pc_plus
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_redirect_cnt
`endif
);

  localparam int unsigned PTR_W = clog2(BUF_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OCC_W = PTR_W + 2;

  if_state_e         state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              infl_q, infl_d;
  logic [PC_W-1:0]   infl_pc_q, infl_pc_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [INST_W-1:0] buf_inst_q [BUF_DEPTH];
  logic [INST_W-1:0] buf_inst_d [BUF_DEPTH];
  logic [PC_W-1:0]   buf_pc_q [BUF_DEPTH];
  logic [PC_W-1:0]   buf_pc_d [BUF_DEPTH];

  logic              mem_we;
  logic [IDX_W-1:0]  mem_addr;
  logic [INST_W-1:0] rdata;
  logic              head_infl, pop, pop_buf, park, issue, flush;
  logic [OCC_W-1:0]  occ;
  logic [INST_W-1:0] head_inst;
  logic [PC_W-1:0]   head_pc;

  assign mem_we   = (state_q == BOOT) && boot_we;
  assign mem_addr = (state_q == BOOT) ? boot_addr : pc_q[IDX_W+1:2];

  if_imem #(.DEPTH(DEPTH), .INST_W(INST_W)) u_imem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (boot_data),
    .rdata (rdata)
  );

  // The in-flight read sits logically behind the buffered entries; it is the head only when the buffer is empty.
  assign head_infl  = (cnt_q == '0);
  assign inst_valid = (cnt_q != '0) || infl_q;
  assign head_inst  = head_infl ? rdata : buf_inst_q[rd_ptr_q];
  assign head_pc    = head_infl ? infl_pc_q : buf_pc_q[rd_ptr_q];
  assign inst         = inst_valid ? head_inst : '0;
  assign inst_pc      = inst_valid ? head_pc : '0;
  assign inst_pc_plus = inst_valid ? PC_W'(head_pc + PC_W'(INST_BYTES)) : '0;
  assign pc_run       = (state_q == RUN);

  assign pop     = inst_valid && inst_ready;
  assign pop_buf = pop && (cnt_q != '0);
  assign park    = infl_q && !(pop && head_infl);
  assign occ     = OCC_W'(cnt_q) + OCC_W'(infl_q) - OCC_W'(pop);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    infl_pc_d  = infl_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    buf_inst_d = buf_inst_q;
    buf_pc_d   = buf_pc_q;
    issue      = 1'b0;
    flush      = 1'b0;

    if (state_q == BOOT) begin
      pc_d  = PC_W'(RESET_PC);
      flush = 1'b1;
      if (!boot_up) state_d = RUN;
    end else if (boot_up) begin
      state_d = BOOT;
      pc_d    = PC_W'(RESET_PC);
      flush   = 1'b1;
    end else if (redirect_valid) begin
      pc_d  = redirect_pc & ~PC_W'(INST_BYTES - 1);
      flush = 1'b1;
    end else if (occ < OCC_W'(BUF_DEPTH)) begin
      issue = 1'b1;
      pc_d  = pc_q + PC_W'(INST_BYTES);
    end

    infl_d = issue;
    if (issue) infl_pc_d = pc_q;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (pop_buf) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (park) begin
        buf_inst_d[wr_ptr_q] = rdata;
        buf_pc_d[wr_ptr_q]   = infl_pc_q;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
      cnt_d = cnt_q + CNT_W'(park) - CNT_W'(pop_buf);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= BOOT;
      pc_q      <= PC_W'(RESET_PC);
      infl_q    <= 1'b0;
      infl_pc_q <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      infl_q    <= infl_d;
      infl_pc_q <= infl_pc_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  // Buffer storage is datapath only; validity comes from cnt_q.
  always_ff @(posedge clk) begin
    buf_inst_q <= buf_inst_d;
    buf_pc_q   <= buf_pc_d;
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d, redir_cnt_q, redir_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    redir_cnt_d = redir_cnt_q;
    if (state_d == BOOT) begin
      fetch_cnt_d = '0;
      redir_cnt_d = '0;
    end else begin
      if (pop) fetch_cnt_d = fetch_cnt_q + 32'd1;
      if ((state_q == RUN) && redirect_valid) redir_cnt_d = redir_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign perf_fetch_cnt    = fetch_cnt_q;
  assign perf_redirect_cnt = redir_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage_pipe.sv
// Bench for if_stage_pipe: queue-based reference model, per-cycle compare, directed and random stimulus.
module tb_if_stage_pipe;

  localparam int unsigned PC_W      = 16;
  localparam int unsigned INST_W    = 32;
  localparam int unsigned DEPTH     = 256;
  localparam int unsigned IDX_W     = 8;
  localparam int unsigned BUF_DEPTH = 2;
  localparam int unsigned RESET_PC  = 0;

  logic              clk = 1'b0;
  logic              rst, boot_up, boot_we, redirect_valid, inst_ready;
  logic [IDX_W-1:0]  boot_addr;
  logic [INST_W-1:0] boot_data;
  logic [PC_W-1:0]   redirect_pc;
  logic              pc_run, inst_valid;
  logic [INST_W-1:0] inst;
  logic [PC_W-1:0]   inst_pc, inst_pc_plus;
`ifdef IF_PERF_CNT_EN
  logic [31:0]       perf_fetch_cnt, perf_redirect_cnt;
`endif

  if_stage_pipe #(
    .PC_W(PC_W), .INST_W(INST_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .boot_up(boot_up), .boot_we(boot_we), .boot_addr(boot_addr),
    .boot_data(boot_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pc_run(pc_run), .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .inst_pc_plus(inst_pc_plus)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_redirect_cnt(perf_redirect_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: visible fetch queue, fetch PC, run flag, memory image.
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] word;
  } ent_t;

  ent_t              vis[$];
  bit                m_run = 1'b0;
  logic [PC_W-1:0]   m_pc = PC_W'(RESET_PC);
  logic [INST_W-1:0] m_mem [DEPTH];
  int unsigned       m_fc = 0;
  int unsigned       m_rc = 0;

  always @(posedge clk) begin
    ent_t e;
    bit   popped;
    if (rst) begin
      m_run = 1'b0; vis.delete(); m_pc = PC_W'(RESET_PC); m_fc = 0; m_rc = 0;
    end else if (!m_run) begin
      if (boot_we) m_mem[boot_addr] = boot_data;
      if (!boot_up) m_run = 1'b1;
      m_pc = PC_W'(RESET_PC); m_fc = 0; m_rc = 0;
    end else begin
      popped = (vis.size() > 0) && inst_ready;
      if (popped) begin void'(vis.pop_front()); m_fc++; end
      if (boot_up) begin
        m_run = 1'b0; vis.delete(); m_pc = PC_W'(RESET_PC); m_fc = 0; m_rc = 0;
      end else if (redirect_valid) begin
        vis.delete(); m_pc = redirect_pc & 16'hFFFC; m_rc++;
      end else if (vis.size() < BUF_DEPTH) begin
        e.pc = m_pc; e.word = m_mem[(m_pc >> 2) % DEPTH];
        vis.push_back(e);
        m_pc = m_pc + 16'd4;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc_run", 64'(pc_run), 64'(m_run));
      chk("inst_valid", 64'(inst_valid), 64'(vis.size() > 0));
      if (vis.size() > 0) begin
        chk("inst", 64'(inst), 64'(vis[0].word));
        chk("inst_pc", 64'(inst_pc), 64'(vis[0].pc));
        chk("inst_pc_plus", 64'(inst_pc_plus), 64'(16'(vis[0].pc + 16'd4)));
      end
`ifdef IF_PERF_CNT_EN
      chk("perf_fetch_cnt", 64'(perf_fetch_cnt), 64'(m_fc));
      chk("perf_redirect_cnt", 64'(perf_redirect_cnt), 64'(m_rc));
`endif
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string nm, input bit ev, input logic [PC_W-1:0] epc,
                           input logic [INST_W-1:0] ew);
    @(negedge clk);
    chk({nm, ".valid"}, 64'(inst_valid), 64'(ev));
    if (ev) begin
      chk({nm, ".pc"}, 64'(inst_pc), 64'(epc));
      chk({nm, ".inst"}, 64'(inst), 64'(ew));
      chk({nm, ".pc_plus"}, 64'(inst_pc_plus), 64'(16'(epc + 16'd4)));
    end
  endtask

  task automatic check_zero(input string nm);
    @(negedge clk);
    chk({nm, ".pc_run"}, 64'(pc_run), 64'(0));
    chk({nm, ".valid"}, 64'(inst_valid), 64'(0));
    chk({nm, ".inst"}, 64'(inst), 64'(0));
    chk({nm, ".pc"}, 64'(inst_pc), 64'(0));
    chk({nm, ".pc_plus"}, 64'(inst_pc_plus), 64'(0));
  endtask

  function automatic logic [INST_W-1:0] img(input int unsigned i);
    if (i < 8) return 32'h1000_0000 + INST_W'(i);
    if (i == 255) return 32'hDEAD_00FF;
    return 32'h2000_0000 + INST_W'(i);
  endfunction

  task automatic redirect_to(input logic [PC_W-1:0] tgt);
    redirect_valid = 1'b1; redirect_pc = tgt;
    nxt();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int boot_left;
    int r;
    rst = 1'b1; boot_up = 1'b1; boot_we = 1'b0; boot_addr = '0; boot_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    nxt(); nxt();
    check_zero("reset");
    rst = 1'b0; chk_en = 1'b1;

    // Boot-load the full image.
    for (int i = 0; i < int'(DEPTH); i++) begin
      boot_we = 1'b1; boot_addr = IDX_W'(i); boot_data = img(i);
      nxt();
    end
    boot_we = 1'b0; boot_up = 1'b0; inst_ready = 1'b1;
    nxt();
    @(negedge clk);
    chk("run_entry.pc_run", 64'(pc_run), 64'(1));
    chk("run_entry.valid", 64'(inst_valid), 64'(0));
    for (int k = 0; k < 8; k++) begin
      nxt();
      check_out("boot_seq", 1'b1, 16'(4 * k), 32'h1000_0000 + 32'(k));
    end
    nxt();

    // Backpressure: head at pc 32 held for five stalled cycles.
    inst_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check_out("stall_hold", 1'b1, 16'h0020, 32'h2000_0008);
      nxt();
    end
    inst_ready = 1'b1;
    check_out("stall_rel0", 1'b1, 16'h0020, 32'h2000_0008);
    nxt();
    check_out("stall_rel1", 1'b1, 16'h0024, 32'h2000_0009);
    nxt();
    check_out("stall_rel2", 1'b1, 16'h0028, 32'h2000_000A);

    // Redirect with a full buffer.
    inst_ready = 1'b0;
    nxt(); nxt(); nxt();
    redirect_to(16'h0023);
    inst_ready = 1'b1;
    check_out("redir_gap", 1'b0, 16'h0, 32'h0);
    nxt();
    check_out("redir_first", 1'b1, 16'h0020, 32'h2000_0008);
    nxt();
    check_out("redir_second", 1'b1, 16'h0024, 32'h2000_0009);

    // Index wrap and PC wrap.
    redirect_to(16'h03FC);
    check_out("wrap_gap", 1'b0, 16'h0, 32'h0);
    nxt();
    check_out("idx_wrap0", 1'b1, 16'h03FC, 32'hDEAD_00FF);
    nxt();
    check_out("idx_wrap1", 1'b1, 16'h0400, 32'h1000_0000);
    redirect_to(16'hFFFC);
    nxt();
    check_out("pc_wrap0", 1'b1, 16'hFFFC, 32'hDEAD_00FF);
    nxt();
    check_out("pc_wrap1", 1'b1, 16'h0000, 32'h1000_0000);

    // Re-boot mid-stream with a new word at index 0.
    nxt();
    boot_up = 1'b1;
    nxt();
    @(negedge clk);
    chk("reboot.pc_run", 64'(pc_run), 64'(0));
    chk("reboot.valid", 64'(inst_valid), 64'(0));
    boot_we = 1'b1; boot_addr = '0; boot_data = 32'hB007_0000;
    nxt();
    boot_we = 1'b0; boot_up = 1'b0;
    nxt();
    nxt();
    check_out("reboot_first", 1'b1, 16'h0000, 32'hB007_0000);

    // Synchronous reset mid-stream.
    nxt(); nxt();
    rst = 1'b1;
    nxt();
    check_zero("reset_mid");
    rst = 1'b0;

    // Ten accepted fetches then two redirects, counted from a fresh boot.
    boot_up = 1'b1;
    nxt();
    boot_up = 1'b0; inst_ready = 1'b1;
    nxt();
    for (int k = 0; k < 11; k++) nxt();
    inst_ready = 1'b0;
    redirect_to(16'h0100);
    nxt();
    redirect_to(16'h0200);
`ifdef IF_PERF_CNT_EN
    @(negedge clk);
    chk("perf_fetch_10", 64'(perf_fetch_cnt), 64'(10));
    chk("perf_redir_2", 64'(perf_redirect_cnt), 64'(2));
    boot_up = 1'b1;
    nxt();
    @(negedge clk);
    chk("perf_fetch_clr", 64'(perf_fetch_cnt), 64'(0));
    chk("perf_redir_clr", 64'(perf_redirect_cnt), 64'(0));
    boot_up = 1'b0;
`endif
    nxt();

    // Randomized traffic: backpressure, redirects, re-boots, resets, ignored boot writes.
    boot_left = 0;
    for (int c = 0; c < 1500; c++) begin
      r = int'($urandom_range(0, 199));
      inst_ready = ($urandom_range(0, 99) < 70);
      redirect_valid = (r < 12);
      redirect_pc = 16'($urandom);
      rst = (r == 199);
      if (r == 198) boot_left = int'($urandom_range(1, 6));
      boot_we = 1'($urandom);
      boot_addr = IDX_W'($urandom);
      boot_data = $urandom;
      if (boot_left > 0) begin
        boot_up = 1'b1;
        boot_left--;
      end else begin
        boot_up = 1'b0;
      end
      nxt();
    end
    rst = 1'b0; boot_up = 1'b0; boot_we = 1'b0; redirect_valid = 1'b0;
    nxt(); nxt();
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
